// File: rtl/mapu_row_packer.sv
// mapu_row_packer: packs a row-major stream of nine elements into a 3x3 matrix for the Matrix APU
module mapu_row_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_last,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [3*DATA_WIDTH-1:0] o_r0,
  output logic [3*DATA_WIDTH-1:0] o_r1,
  output logic [3*DATA_WIDTH-1:0] o_r2,
  output logic                    o_err,
  output logic [7:0]              o_err_cnt
);
  localparam int MW = 9 * DATA_WIDTH;
  typedef enum logic {FILLING, PENDING} fill_t;
  fill_t r_state, w_state_nxt;
  logic [3:0] r_idx;
  logic [MW-1:0] r_buf, r_out;
  logic r_vld, r_err;
  logic [7:0] r_err_cnt;
  logic w_acc, w_beat, w_end, w_err, w_done, w_load_new, w_load_pend;
  logic [MW-1:0] w_full;
  assign w_acc       = i_vld & o_rdy;
  assign w_beat      = r_vld & i_rdy;
  assign w_end       = r_idx == 4'd8;
  assign w_err       = w_acc & (i_last ^ w_end);
  assign w_done      = w_acc & i_last & w_end;
  assign w_load_new  = w_done & (~r_vld | w_beat);
  assign w_load_pend = (r_state == PENDING) & w_beat;
  // the final element bypasses the fill buffer when OUT can take the matrix directly
  assign w_full      = {i_data, r_buf[MW-DATA_WIDTH-1:0]};
  always_ff @(posedge clk) begin
    if (reset) r_state <= FILLING;
    else       r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = (r_state == FILLING) ? ((w_done & ~w_load_new) ? PENDING : FILLING)
                                       : (w_beat ? FILLING : PENDING);
  end
  always_comb begin
    o_rdy = ~reset & (r_state == FILLING);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= 4'd0;
      r_buf     <= '0;
      r_out     <= '0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_err;
      if (w_err && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_acc) begin
        r_idx <= (w_err || w_done) ? 4'd0 : r_idx + 4'd1;
        r_buf[r_idx*DATA_WIDTH +: DATA_WIDTH] <= i_data;
      end
      if (w_load_new)       r_out <= w_full;
      else if (w_load_pend) r_out <= r_buf;
      r_vld <= w_load_new | w_load_pend | (r_vld & ~w_beat);
    end
  end
  assign o_vld     = r_vld;
  assign o_r0      = r_out[3*DATA_WIDTH-1:0];
  assign o_r1      = r_out[6*DATA_WIDTH-1:3*DATA_WIDTH];
  assign o_r2      = r_out[MW-1:6*DATA_WIDTH];
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_mapu_row_packer.sv
// tb_mapu_row_packer: vector table, directed corner sequences and a queue-based random scoreboard
module tb_mapu_row_packer;
  localparam int DW = 8;
  localparam int MW = 9 * DW;
  logic clk = 0, reset = 1, i_vld = 0, i_last = 0, i_rdy = 0;
  logic [DW-1:0] i_data = '0;
  logic o_rdy, o_vld, o_err;
  logic [3*DW-1:0] o_r0, o_r1, o_r2;
  logic [7:0] o_err_cnt;
  int total = 0, bad = 0;
  mapu_row_packer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data),
    .i_last(i_last), .o_vld(o_vld), .i_rdy(i_rdy), .o_r0(o_r0), .o_r1(o_r1),
    .o_r2(o_r2), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic vld; logic [DW-1:0] d; logic last; logic rdy;
    logic e_rdy; logic e_vld; logic e_err; logic [7:0] e_cnt;
    logic chk_rows; logic [MW-1:0] e_m;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [MW-1:0] mat(input int base);
    logic [MW-1:0] m;
    for (int k = 0; k < 9; k++) m[k*DW +: DW] = DW'(base + k);
    return m;
  endfunction
  function automatic vec_t mkv(input logic v, input int d, input logic l, input logic r,
                               input logic er, input logic ev, input logic ee, input int ec,
                               input logic cr, input int base);
    vec_t x;
    x.vld = v; x.d = DW'(d); x.last = l; x.rdy = r;
    x.e_rdy = er; x.e_vld = ev; x.e_err = ee; x.e_cnt = 8'(ec);
    x.chk_rows = cr; x.e_m = mat(base);
    return x;
  endfunction
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    i_vld = v; i_data = d; i_last = l; i_rdy = r;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0; #1;
  endtask
  // scoreboard: completed matrices waiting downstream, partial element list, error tally
  logic mon_en = 0;
  logic [DW-1:0] part[$];
  logic [MW-1:0] expq[$];
  int m_errs = 0;
  logic m_err = 0;
  always @(negedge clk) if (mon_en) begin
    logic beat, acc;
    logic [MW-1:0] m;
    chk("m_vld", o_vld, expq.size() != 0);
    chk("m_rdy", o_rdy, expq.size() < 2);
    if (expq.size() != 0) chk("m_rows", {o_r2, o_r1, o_r0}, expq[0]);
    chk("m_err", o_err, m_err);
    chk("m_cnt", o_err_cnt, m_errs > 255 ? 255 : m_errs);
    m_err = 0;
    beat = (expq.size() != 0) && i_rdy;
    acc = i_vld && (expq.size() < 2);
    if (beat) void'(expq.pop_front());
    if (acc) begin
      part.push_back(i_data);
      if (i_last || part.size() == 9) begin
        if (i_last && part.size() == 9) begin
          for (int k = 0; k < 9; k++) m[k*DW +: DW] = part[k];
          expq.push_back(m);
        end else begin
          m_err = 1;
          m_errs++;
        end
        part.delete();
      end
    end
  end
  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_rows", {o_r2, o_r1, o_r0}, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", o_err_cnt, 0);
    reset = 0; #1;
    chk("rdy_after_rst", o_rdy, 1);
    // basic matrix, then an early-last frame followed by a clean one
    for (int i = 1; i <= 9; i++) tbl.push_back(mkv(1, i, i == 9, 1, 1, i == 9, 0, 0, i == 9, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(1, 100 + i, i == 4, 1, 1, 0, i == 4, i == 4, 0, 0));
    for (int i = 21; i <= 29; i++) tbl.push_back(mkv(1, i, i == 29, 1, 1, i == 29, 0, 1, i == 29, 21));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    foreach (tbl[n]) begin
      step(tbl[n].vld, tbl[n].d, tbl[n].last, tbl[n].rdy);
      chk("t_rdy", o_rdy, tbl[n].e_rdy);
      chk("t_vld", o_vld, tbl[n].e_vld);
      chk("t_err", o_err, tbl[n].e_err);
      chk("t_cnt", o_err_cnt, tbl[n].e_cnt);
      if (tbl[n].chk_rows) chk("t_rows", {o_r2, o_r1, o_r0}, tbl[n].e_m);
    end
    // backpressure: two matrices queued behind a stalled consumer
    do_reset();
    for (int i = 1; i <= 18; i++) step(1, DW'(i), i == 9 || i == 18, 0);
    chk("bp_rdy", o_rdy, 0);
    chk("bp_vld", o_vld, 1);
    chk("bp_rows1", {o_r2, o_r1, o_r0}, mat(1));
    step(0, 0, 0, 0);
    chk("bp_hold", {o_r2, o_r1, o_r0}, mat(1));
    chk("bp_rdy_hold", o_rdy, 0);
    step(0, 0, 0, 1);
    chk("bp_vld2", o_vld, 1);
    chk("bp_rows2", {o_r2, o_r1, o_r0}, mat(10));
    chk("bp_rdy2", o_rdy, 1);
    step(0, 0, 0, 1);
    chk("bp_drain", o_vld, 0);
    // missing last on the ninth element
    do_reset();
    for (int i = 0; i < 9; i++) step(1, DW'(50 + i), 0, 1);
    chk("ml_err", o_err, 1);
    chk("ml_cnt", o_err_cnt, 1);
    chk("ml_vld", o_vld, 0);
    for (int i = 60; i <= 68; i++) step(1, DW'(i), i == 68, 1);
    chk("ml_vld2", o_vld, 1);
    chk("ml_rows", {o_r2, o_r1, o_r0}, mat(60));
    chk("ml_err2", o_err, 0);
    step(0, 0, 0, 1);
    // reset while a matrix is held and another is part-filled
    step(1, 8'hee, 1, 0);
    for (int i = 1; i <= 9; i++) step(1, DW'(i), i == 9, 0);
    for (int i = 30; i < 34; i++) step(1, DW'(i), 0, 0);
    chk("rm_pre_vld", o_vld, 1);
    chk("rm_pre_cnt", o_err_cnt, 2);
    reset = 1;
    step(0, 0, 0, 0);
    chk("rm_vld", o_vld, 0);
    chk("rm_rows", {o_r2, o_r1, o_r0}, 0);
    chk("rm_cnt", o_err_cnt, 0);
    chk("rm_rdy", o_rdy, 0);
    reset = 0; #1;
    chk("rm_rdy_rel", o_rdy, 1);
    for (int i = 70; i <= 78; i++) step(1, DW'(i), i == 78, 1);
    chk("rm_vld2", o_vld, 1);
    chk("rm_rows2", {o_r2, o_r1, o_r0}, mat(70));
    chk("rm_cnt2", o_err_cnt, 0);
    step(0, 0, 0, 1);
    // saturation of the error counter
    do_reset();
    for (int i = 0; i < 300; i++) step(1, DW'(i), 1, 1);
    chk("sat_cnt", o_err_cnt, 255);
    chk("sat_err", o_err, 1);
    step(0, 0, 0, 1);
    chk("sat_err_off", o_err, 0);
    // randomized traffic against the scoreboard
    do_reset();
    mon_en = 1;
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      i_rdy = ($urandom % 3) != 0;
      i_vld = ($urandom % 4) != 0;
      i_data = DW'($urandom);
      i_last = ($urandom % 16 == 0) ? !(cnt == 8) : (cnt == 8);
      if (i_vld && o_rdy) cnt = (i_last || cnt == 8) ? 0 : cnt + 1;
      @(posedge clk); #1;
    end
    i_vld = 0; i_rdy = 1;
    repeat (4) begin @(posedge clk); #1; end
    mon_en = 0;
    chk("rnd_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mapu_row_packer.md
MAPU_ROW_PACKER -- requirements
Module: mapu_row_packer

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of one matrix element in bits.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 The block SHALL have port i_vld, input, 1 bit: upstream element valid.
- REQ-005 The block SHALL have port o_rdy, output, 1 bit: the block can accept an element.
- REQ-006 The block SHALL have port i_data, input, DATA_WIDTH bits: one matrix element.
- REQ-007 The block SHALL have port i_last, input, 1 bit: upstream marks the final element of a matrix.
- REQ-008 The block SHALL have port o_vld, output, 1 bit: a packed 3x3 matrix is presented downstream.
- REQ-009 The block SHALL have port i_rdy, input, 1 bit: the downstream Matrix APU accepts the matrix.
- REQ-010 The block SHALL have ports o_r0, o_r1 and o_r2, outputs, 3*DATA_WIDTH bits each: matrix rows 0, 1 and 2.
- REQ-011 The block SHALL have port o_err, output, 1 bit: one-cycle pulse indicating a framing error.
- REQ-012 The block SHALL have port o_err_cnt, output, 8 bits: saturating count of framing errors.

Function
- REQ-013 An element beat SHALL be transferred only on a rising edge where i_vld=1 and o_rdy=1; an output beat SHALL be transferred only where o_vld=1 and i_rdy=1.
- REQ-014 Elements SHALL be row-major: element index k (0..8) lands in row k/3, column k%3, with column 0 in bits [DATA_WIDTH-1:0].
- REQ-015 A 4-bit index counter SHALL count accepted elements 0..8 and return to 0 after index 8 or after any framing error.
- REQ-016 The block SHALL hold two storage stages: a fill buffer (FILL) and an output register (OUT); the fill buffer has states FILLING and PENDING.
- REQ-017 On acceptance of index 8 with i_last=1, the fill buffer contents SHALL move into OUT on that same edge when OUT is empty or an output beat occurs that cycle; o_vld SHALL then be 1 on the next cycle (1-cycle latency from the last element).
- REQ-018 Otherwise, on acceptance of index 8 with i_last=1, FILL SHALL enter PENDING with o_rdy=0; FILL moves into OUT on the edge of the next output beat, o_vld stays 1, and FILL returns to FILLING with o_rdy=1 the following cycle.
- REQ-019 o_rdy SHALL be 1 exactly when the block is out of reset and FILL is in FILLING.
- REQ-020 o_r0..o_r2 SHALL remain stable while o_vld=1 and i_rdy=0; o_vld SHALL fall after an output beat unless a new matrix is loaded on that same edge.
- REQ-021 i_last=1 on an index below 8 SHALL discard the partial matrix and reset the counter to 0.
- REQ-022 i_last=0 on index 8 SHALL discard the partial matrix and reset the counter to 0.
- REQ-023 Each framing error (REQ-021, REQ-022) SHALL pulse o_err for exactly one cycle, the cycle after the offending beat, and SHALL increment o_err_cnt, saturating at 255.
- REQ-024 A framing error SHALL NOT disturb OUT or an in-progress output transfer.
- REQ-025 Elements not transferred (i_vld=0 or o_rdy=0) SHALL leave the counter and buffer unchanged; i_data and i_last SHALL be ignored when i_vld=0.

Reset
- REQ-026 While reset=1 on a clock edge, the block SHALL force o_vld=0, o_rdy=0, o_err=0, o_err_cnt=0, o_r0=o_r1=o_r2=0, counter=0, and FILL=FILLING with contents discarded.
- REQ-027 o_rdy SHALL be 1 on the first cycle after reset deasserts.
- REQ-028 Reset asserted mid-matrix or with o_vld=1 SHALL drop all buffered data without emitting it.

Verification
- REQ-029 Basic: with i_rdy=1, send 1..9 with i_last on the 9th element; expect o_vld=1 one cycle later, o_r0={3,2,1}, o_r1={6,5,4}, o_r2={9,8,7}, and o_err=0.
- REQ-030 Backpressure: hold i_rdy=0, send two matrices (1..9 then 10..18); expect o_rdy=0 after the 18th beat and the first matrix held stable; raise i_rdy to get matrix 1 then matrix 2 in order, with o_rdy=1 the cycle after the second handover.
- REQ-031 Early last: i_last on the 5th element, then a clean 21..29 matrix; expect one o_err pulse, o_err_cnt=1, and only the 21..29 matrix emitted.
- REQ-032 Missing last: 9 elements with i_last=0 followed by a clean matrix; expect an o_err pulse and o_err_cnt=1, with the first 9 elements never emitted.
- REQ-033 Reset mid-operation: assert reset after 4 elements and with o_vld=1; expect all outputs 0, o_rdy=1 after release, and the next matrix to start at index 0.
- REQ-034 Saturation: inject 300 framing errors; expect o_err_cnt=255.
